// File: rtl/ifu_pkg.sv
// ============================================================================
// Module      : ifu_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_pkg;

   localparam int                    IFU_ADDR_W   = 32;
   localparam int                    INSTR_W      = 32;
   localparam logic [IFU_ADDR_W-1:0] IFU_RESET_PC = 32'h0000_0000;
   localparam logic [IFU_ADDR_W-1:0] PC_INC       = 32'd4;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } ifu_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0]    instr;
      logic [IFU_ADDR_W-1:0] pc;
   } fetch_entry_t;

   function automatic logic [IFU_ADDR_W-1:0] align_pc(input logic [IFU_ADDR_W-1:0] pc);
      return {pc[IFU_ADDR_W-1:2], 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Instruction-memory request/response and decode handshake bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if #(
   parameter int ADDR_W = 32
) ();

   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_rsp_valid;
   logic [31:0]       imem_rsp_data;
   logic              instr_valid;
   logic              instr_ready;
   logic [31:0]       instr;
   logic [ADDR_W-1:0] instr_pc;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output instr_valid, instr, instr_pc,
      input  instr_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  instr_valid, instr, instr_pc,
      output instr_ready
   );

endinterface

`default_nettype wire

// File: rtl/ifu_fifo.sv
// ============================================================================
// Module      : ifu_fifo
// Description : Synchronous FIFO of fetch entries with flush and count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fifo
   import ifu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  fetch_entry_t           i_data,
   input  logic                   i_pop,
   output fetch_entry_t           o_head,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_full;
   logic w_do_push;
   logic w_do_pop;

   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!w_full || w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
      end
   end

   // The fetch credit scheme must never let a push hit a full buffer.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(i_push && w_full && !i_pop && !i_flush));

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC owner, in-order imem requester and decode-side buffer.
//               Optional perf counters are enabled by IFU_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter int                ADDR_W     = IFU_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC   = IFU_RESET_PC,
   parameter int                FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   instr_fetch_unit_if.master   bus,
   input  logic                 redirect,
   input  logic [ADDR_W-1:0]    redirect_pc
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]          perf_fetched,
   output logic [31:0]          perf_dropped
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   ifu_state_e        r_state;
   ifu_state_e        w_state_nxt;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] r_rsp_pc;
   logic [CNT_W-1:0]  r_outstanding;
   logic [CNT_W-1:0]  r_drop_cnt;

   logic [CNT_W-1:0]  w_count;
   logic              w_empty;
   fetch_entry_t      w_head;
   fetch_entry_t      w_push_entry;
   logic [CNT_W:0]    w_credit_used;
   logic              w_req_valid;
   logic              w_req_fire;
   logic              w_rsp_drop;
   logic              w_push;
   logic              w_pop;
   logic [CNT_W-1:0]  w_out_nxt;
   logic [CNT_W-1:0]  w_drop_nxt;

   assign w_credit_used = {1'b0, w_count} + {1'b0, r_outstanding};
   assign w_req_fire    = w_req_valid && bus.imem_req_ready;
   assign w_rsp_drop    = bus.imem_rsp_valid && (redirect || (r_drop_cnt != '0));
   assign w_push        = bus.imem_rsp_valid && !w_rsp_drop;
   assign w_pop         = !w_empty && bus.instr_ready && !redirect;
   assign w_out_nxt     = r_outstanding + CNT_W'(w_req_fire) - CNT_W'(bus.imem_rsp_valid);

   assign w_push_entry.instr = bus.imem_rsp_data;
   assign w_push_entry.pc    = r_rsp_pc;

   always_comb begin
      w_state_nxt = r_state;
      w_drop_nxt  = r_drop_cnt;
      w_req_valid = rst_n && (r_state == RUN) && !redirect &&
                    (w_credit_used < (CNT_W+1)'(FIFO_DEPTH));
      // A redirect re-arms the drop counter with everything still in flight.
      if (redirect) begin
         w_drop_nxt = w_out_nxt;
      end else if (bus.imem_rsp_valid && (r_drop_cnt != '0)) begin
         w_drop_nxt = r_drop_cnt - CNT_W'(1);
      end
      case (r_state)
         RUN:     if (w_drop_nxt != '0) w_state_nxt = DRAIN;
         DRAIN:   if (w_drop_nxt == '0) w_state_nxt = RUN;
         default: w_state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= RUN;
         r_fetch_pc    <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_outstanding <= w_out_nxt;
         r_drop_cnt    <= w_drop_nxt;
         if (redirect) begin
            r_fetch_pc <= align_pc(redirect_pc);
            r_rsp_pc   <= align_pc(redirect_pc);
         end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + PC_INC;
            if (w_push)     r_rsp_pc   <= r_rsp_pc + PC_INC;
         end
      end
   end

   ifu_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (redirect),
      .i_push  (w_push),
      .i_data  (w_push_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_addr  = r_fetch_pc;
   assign bus.instr_valid    = !w_empty;
   assign bus.instr          = w_empty ? '0 : w_head.instr;
   assign bus.instr_pc       = w_empty ? '0 : w_head.pc;

`ifdef IFU_PERF_CNT_EN
   logic [31:0]    r_perf_fetched;
   logic [31:0]    r_perf_dropped;
   logic [CNT_W:0] w_drop_add;
   logic [32:0]    w_drop_sum;

   // Flushed buffer words and discarded responses both count as dropped.
   assign w_drop_add = (redirect ? {1'b0, w_count} : '0) + (CNT_W+1)'(w_rsp_drop);
   assign w_drop_sum = {1'b0, r_perf_dropped} + 33'(w_drop_add);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_fetched <= '0;
         r_perf_dropped <= '0;
      end else begin
         if (w_pop && (r_perf_fetched != 32'hFFFF_FFFF)) begin
            r_perf_fetched <= r_perf_fetched + 32'd1;
         end
         r_perf_dropped <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_dropped = r_perf_dropped;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Scoreboard bench for instr_fetch_unit with an in-order memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_dropped;
`endif

   always #5 clk = ~clk;

   instr_fetch_unit_if #(.ADDR_W(32)) bus ();

   instr_fetch_unit #(
      .ADDR_W       (32),
      .RESET_PC     (32'h0000_0100),
      .FIFO_DEPTH   (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_dropped (perf_dropped)
`endif
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int          n_fire = 0;
   int          n_deliv = 0;
   int unsigned cyc = 0;
   int unsigned lat = 1;
   logic [31:0] exp_addr[$];
   logic [31:0] exp_pc[$];
   logic [31:0] pend_addr[$];
   int unsigned pend_due[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC3A5_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_addrs(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) exp_addr.push_back(start + 32'(4 * i));
   endtask

   task automatic expect_instrs(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) exp_pc.push_back(start + 32'(4 * i));
   endtask

   // Memory model: in-order, fixed latency `lat`, reset by rst_n.
   initial begin
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.instr_ready    = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
            pend_addr.push_back(bus.imem_req_addr);
            pend_due.push_back(cyc + lat);
         end
         @(posedge clk);
         #1;
         cyc++;
         if (!rst_n) begin
            pend_addr.delete();
            pend_due.delete();
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
         end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
         end
      end
   end

   // Monitor: compares every accepted request and every consumed instruction.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
               n_fire++;
               if (exp_addr.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL req_addr: got %h expected no request", bus.imem_req_addr);
               end else begin
                  check("req_addr", bus.imem_req_addr, exp_addr.pop_front());
               end
            end
            if (bus.instr_valid && bus.instr_ready && !redirect) begin
               n_deliv++;
               if (exp_pc.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL instr_pc: got %h expected no instruction", bus.instr_pc);
               end else begin
                  e = exp_pc.pop_front();
                  check("instr_pc", bus.instr_pc, e);
                  check("instr", bus.instr, mem_word(e));
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      check("rst_instr", bus.instr, 32'd0);
      check("rst_instr_pc", bus.instr_pc, 32'd0);
      exp_addr.delete();
      exp_pc.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      n_fire  = 0;
      n_deliv = 0;
   endtask

   task automatic finish_test(input int drop_exp, input string name);
      bit ok;
      ok = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.instr_ready    = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #2;
         if (pend_addr.size() == 0 && !bus.imem_rsp_valid && !bus.instr_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_drained"}, 32'(ok), 32'd1);
      check({name, "_delivered"}, 32'(n_deliv), 32'(n_fire - drop_exp));
      exp_addr.delete();
      exp_pc.delete();
   endtask

   initial begin
      // Back-pressure from reset, then free-running stream.
      lat = 1;
      bus.instr_ready = 1'b0;
      bus.imem_req_ready = 1'b1;
      do_reset();
      expect_addrs(32'h100, 40);
      expect_instrs(32'h100, 40);
      repeat (10) @(posedge clk);
      #2;
      check("bp_req_count", 32'(n_fire), 32'd2);
      check("bp_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("bp_instr_valid", 32'(bus.instr_valid), 32'd1);
      check("bp_head_pc", bus.instr_pc, 32'h100);
      bus.instr_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      finish_test(0, "stream");

      // Redirect with two responses outstanding, latency 3.
      lat = 3;
      do_reset();
      bus.imem_req_ready = 1'b1;
      expect_addrs(32'h100, 2);
      expect_addrs(32'h2000, 40);
      expect_instrs(32'h2000, 40);
      repeat (2) @(posedge clk);
      #1;
      redirect = 1'b1;
      redirect_pc = 32'h2002;
      #1;
      check("redir_no_req", 32'(bus.imem_req_valid), 32'd0);
      @(posedge clk);
      #1;
      redirect = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      finish_test(2, "redir2");
`ifdef IFU_PERF_CNT_EN
      check("perf_dropped", perf_dropped, 32'd2);
      check("perf_fetched", perf_fetched, 32'(n_deliv));
`endif

      // Redirect in the same cycle the single outstanding response returns.
      lat = 2;
      do_reset();
      bus.imem_req_ready = 1'b1;
      expect_addrs(32'h100, 1);
      expect_addrs(32'h3000, 40);
      expect_instrs(32'h3000, 40);
      @(posedge clk);
      #1;
      bus.imem_req_ready = 1'b0;
      @(posedge clk);
      #1;
      redirect = 1'b1;
      redirect_pc = 32'h3000;
      @(posedge clk);
      #1;
      redirect = 1'b0;
      bus.imem_req_ready = 1'b1;
      #1;
      check("same_cyc_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("same_cyc_req_addr", bus.imem_req_addr, 32'h3000);
      repeat (20) @(posedge clk);
      #1;
      finish_test(1, "redir_rsp");

      // Back-to-back redirects while draining.
      lat = 3;
      do_reset();
      bus.imem_req_ready = 1'b1;
      expect_addrs(32'h100, 2);
      expect_addrs(32'h800, 40);
      expect_instrs(32'h800, 40);
      repeat (2) @(posedge clk);
      #1;
      redirect = 1'b1;
      redirect_pc = 32'h400;
      @(posedge clk);
      #1;
      redirect_pc = 32'h800;
      @(posedge clk);
      #1;
      redirect = 1'b0;
      check("drain_req_valid", 32'(bus.imem_req_valid), 32'd0);
      repeat (20) @(posedge clk);
      #1;
      finish_test(2, "redir_drain");
`ifdef IFU_PERF_CNT_EN
      check("perf_dropped_drain", perf_dropped, 32'd2);
`endif

      // PC wrap, then asynchronous reset while requests are in flight.
      lat = 1;
      do_reset();
      bus.imem_req_ready = 1'b0;
      expect_addrs(32'hFFFF_FFFC, 40);
      expect_instrs(32'hFFFF_FFFC, 40);
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      @(posedge clk);
      #1;
      redirect = 1'b0;
      bus.imem_req_ready = 1'b1;
      check("wrap_first_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
      repeat (8) @(posedge clk);
      #1;
      check("wrap_delivered", 32'(n_deliv >= 3), 32'd1);
      do_reset();
      expect_addrs(32'h100, 40);
      expect_instrs(32'h100, 40);
      #1;
      check("post_rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("post_rst_req_addr", bus.imem_req_addr, 32'h100);
      repeat (15) @(posedge clk);
      #1;
      finish_test(0, "post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer end of the instruction path. Owns the PC, issues in-order read requests to instruction memory, and buffers returned words in a small FIFO.
- Presents {instr, pc} to the decode stage over a valid/ready handshake.
- Accepts redirects from branch/jump resolution and discards stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2); also the maximum number of outstanding requests
ADDR_W, 32, PC/address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  read request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  word-aligned fetch address
imem_rsp_valid  in  1  read data valid; in order, latency >=1 cycle, no backpressure
imem_rsp_data  in  32  returned instruction word
instr_valid  out  1  FIFO head valid toward decode
instr_ready  in  1  decode consumes head
instr  out  32  head instruction word
instr_pc  out  ADDR_W  PC of head instruction
redirect  in  1  one-cycle pulse: flush and restart fetch
redirect_pc  in  ADDR_W  new fetch PC; bits [1:0] ignored (forced 0)

Behaviour:
- Reset (async assert, sync deassert by the user):
  - Outputs and state: fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
  - Reset mid-transaction abandons all in-flight requests. Memory is reset by the same rst_n.
- States:
  - RUN: normal fetch.
  - DRAIN: drop_cnt>0 and no new requests pending; responses are counted and discarded.
  - Transitions:
    - RUN->DRAIN on redirect when outstanding responses exist, excluding any response arriving in the redirect cycle.
    - DRAIN->RUN when drop_cnt reaches 0.
    - Redirect with nothing outstanding stays in RUN.
- Request issue:
  - imem_req_valid=1 when count+outstanding<FIFO_DEPTH, state is RUN, and redirect=0.
  - imem_req_addr=fetch_pc.
  - On valid&&ready: fetch_pc+=4 (wraps modulo 2^ADDR_W) and outstanding increments.
  - A pending request may be withdrawn only by redirect.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If drop_cnt>0: decrement drop_cnt and discard the word.
  - Otherwise: push {data, pc_of_request} into the FIFO. PCs are tracked by a parallel PC queue or by a pc-of-next-response register incremented by 4.
  - Credit rule guarantees the FIFO never overflows. An overflow is an assertion failure.
- Dequeue:
  - instr_valid = FIFO non-empty; instr/instr_pc = head.
  - Pop on instr_valid&&instr_ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - A response arriving while the FIFO is empty is visible on instr_valid the next cycle (1-cycle buffer latency).
- Redirect (highest priority):
  - Same cycle: FIFO cleared, no request issued, no pop counted.
  - drop_cnt = outstanding_after_this_cycle (includes a request accepted in the redirect cycle is impossible, since req_valid=0).
  - A response arriving in the redirect cycle is dropped and excluded from drop_cnt.
  - Next cycle: fetch_pc=redirect_pc&~3.
  - Redirect during DRAIN: the FIFO is already empty; drop_cnt is kept (minus any response this cycle) and fetch_pc is updated.
  - Redirect while full and stalled behaves the same way.
- Back-pressure: instr_ready=0 indefinitely fills the FIFO, then stops requests. No words are lost.

Optional Feature:
IFU_PERF_CNT_EN
- Defined: adds outputs perf_fetched (32, increments per pop) and perf_dropped (32, increments per discarded or flushed word). Both are reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package ifu_pkg:
  - RESET_PC default
  - instruction word width constant (32)
  - PC increment constant (4)
  - state enum {RUN, DRAIN}
  - typedef fetch_entry_t {instr[31:0], pc[ADDR_W-1:0]}
- One sub-module: ifu_fifo.
  - Synchronous FIFO of fetch_entry_t, DEPTH parameter.
  - Supports flush, simultaneous push/pop, and a count output.

Test Plan:
- Reset with RESET_PC=0x100, memory latency 1, ready always 1, instr_ready=1 -> addresses 0x100, 0x104, 0x108, ...; instr_pc follows the same sequence; one instruction per cycle after a 2-cycle startup.
- instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH (2) requests issued, then imem_req_valid=0; releasing ready delivers 0x100, 0x104 in order with no loss.
- Memory latency 3 with 2 outstanding, redirect to 0x2002 -> both stale responses discarded (perf_dropped=2 if enabled); the next request addr is 0x2000 and the first instr_pc is 0x2000.
- Redirect in the same cycle as a response arrives, with 1 outstanding -> that word is dropped, drop_cnt=0, the next address is the redirect target.
- Two back-to-back redirects (0x400 then 0x800) during DRAIN -> no word from 0x400 delivered; first delivered instr_pc=0x800.
- fetch_pc=0xFFFF_FFFC -> next request 0x0000_0000; assert rst_n low mid-flight -> instr_valid=0 and next address RESET_PC.
